// File: rtl/bnn_pkg.sv
// Definitions shared by every BNN stage: the top-level sequencer states and the
// network geometry constants.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_LOAD    = 3'd1,
    s_LAYER_1 = 3'd2,
    s_LAYER_2 = 3'd3,
    s_LAYER_3 = 3'd4
  } state_t;

  localparam int IMG_DIM = 28;
  localparam int N_FILT  = 8;
  localparam int K       = 3;

endpackage

// File: rtl/input_loader_if.sv
// Valid/ready byte stream into the input loader. The source drives valid and data.
// The loader drives ready.
interface input_loader_if #(
  parameter int BEAT_W = 8
);

  logic              in_valid;
  logic [BEAT_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/input_loader.sv
// Streams the pixel bits, the layer-1 kernel bits and a trailing XOR checksum byte
// into one shift register. The pixels/weights outputs are fixed slices of that register.
module input_loader #(
  parameter int IMG_DIM = bnn_pkg::IMG_DIM,
  parameter int N_FILT  = bnn_pkg::N_FILT,
  parameter int K       = bnn_pkg::K,
  parameter int BEAT_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  bnn_pkg::state_t                    state,
  input_loader_if.slave                      bus,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0]    pixels,
  output logic [N_FILT-1:0][K-1:0][K-1:0]    weights,
  output logic                               load_done,
  output logic                               chk_err
);

  import bnn_pkg::*;

  localparam int NPIX  = IMG_DIM * IMG_DIM;
  localparam int NBITS = NPIX + N_FILT * K * K;
  localparam int NDATA = NBITS / BEAT_W;
  localparam int CNT_W = $clog2(NDATA + 1);

  if ((NBITS % BEAT_W) != 0) begin : g_bad_beat_width
    $error("input_loader: frame size %0d is not a multiple of BEAT_W %0d", NBITS, BEAT_W);
  end

  typedef enum logic [1:0] {
    L_IDLE,
    L_RECV,
    L_CHK,
    L_DONE
  } load_state_t;

  load_state_t       fsm;
  logic [CNT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0] xor_acc;
  logic [NBITS-1:0]  sreg;

  // Ready drops in the same cycle the sequencer leaves s_LOAD, so an abort never takes a beat.
  assign bus.in_ready = ((fsm == L_RECV) || (fsm == L_CHK)) && (state == s_LOAD);

  assign pixels  = sreg[NPIX-1:0];
  assign weights = sreg[NBITS-1:NPIX];

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= L_IDLE;
      beat_cnt  <= '0;
      xor_acc   <= '0;
      sreg      <= '0;
      load_done <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      case (fsm)
        L_IDLE: begin
          if (state == s_LOAD) begin
            fsm       <= L_RECV;
            beat_cnt  <= '0;
            xor_acc   <= '0;
            load_done <= 1'b0;
            chk_err   <= 1'b0;
          end
        end
        // Beats enter at the top and walk toward bit 0, so beat 0 ends up in the lowest bits.
        L_RECV: begin
          if (state != s_LOAD) begin
            fsm       <= L_IDLE;
            load_done <= 1'b0;
          end else if (bus.in_valid) begin
            sreg     <= {bus.in_data, sreg[NBITS-1:BEAT_W]};
            xor_acc  <= xor_acc ^ bus.in_data;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == CNT_W'(NDATA - 1)) begin
              fsm <= L_CHK;
            end
          end
        end
        L_CHK: begin
          if (state != s_LOAD) begin
            fsm       <= L_IDLE;
            load_done <= 1'b0;
          end else if (bus.in_valid) begin
            chk_err   <= (bus.in_data != xor_acc);
            load_done <= 1'b1;
            fsm       <= L_DONE;
          end
        end
        L_DONE: begin
          if (state != s_LOAD) begin
            fsm <= L_IDLE;
          end
        end
        default: fsm <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: nominal, bad checksum, gaps, abort and mid-load reset.
module tb_input_loader;
  import bnn_pkg::*;

  localparam int NPIX  = IMG_DIM * IMG_DIM;
  localparam int NBITS = NPIX + N_FILT * K * K;
  localparam int NDATA = NBITS / 8;

  logic clk;
  logic rst;
  state_t state;
  logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels;
  logic [N_FILT-1:0][K-1:0][K-1:0] weights;
  logic load_done;
  logic chk_err;

  int tests_run;
  int tests_failed;
  logic [NBITS-1:0] exp_img;

  input_loader_if #(.BEAT_W(8)) bus ();

  input_loader #(.BEAT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .bus       (bus),
    .pixels    (pixels),
    .weights   (weights),
    .load_done (load_done),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [NBITS-1:0] actual,
                             input logic [NBITS-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic applyStimulus(input logic [7:0] data, input int gap);
    bit accepted = 0;
    int budget = 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hA5;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    while (!accepted && budget < 20) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        accepted = 1;
      end else begin
        @(negedge clk);
        budget++;
      end
    end
    if (!accepted) checkOutput("handshake_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic sendStream(input logic [7:0] chk, input int max_gap);
    for (int n = 0; n < NDATA; n++) applyStimulus(8'(n), $urandom_range(0, max_gap));
    applyStimulus(chk, $urandom_range(0, max_gap));
    bus.in_valid = 1'b0;
  endtask

  task automatic checkImage(input string tag);
    checkOutput({tag, "_pixels"}, NBITS'(pixels), NBITS'(exp_img[NPIX-1:0]));
    checkOutput({tag, "_weights"}, NBITS'(weights), NBITS'(exp_img[NBITS-1:NPIX]));
  endtask

  task automatic restartLoad();
    state = s_IDLE;
    @(negedge clk);
    state = s_LOAD;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int n = 0; n < NDATA; n++) exp_img[n*8 +: 8] = 8'(n);

    rst          = 1'b1;
    state        = s_IDLE;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_pixels", NBITS'(pixels), 0);
    checkOutput("rst_weights", NBITS'(weights), 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_chk_err", chk_err, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);

    // Nominal frame: beat n carries n, XOR of 0..106 is 0x6B.
    rst   = 1'b0;
    state = s_LOAD;
    sendStream(8'h6B, 0);
    checkOutput("nom_load_done", load_done, 1);
    checkOutput("nom_chk_err", chk_err, 0);
    checkOutput("nom_ready_done", bus.in_ready, 0);
    checkImage("nom");
    checkOutput("nom_px_0_8", pixels[0][8], 1);
    checkOutput("nom_px_0_9", pixels[0][9], 0);
    checkOutput("nom_w_000", weights[0][0][0], 0);
    checkOutput("nom_w_001", weights[0][0][1], 1);
    state = s_IDLE;
    @(negedge clk);
    checkOutput("idle_hold_done", load_done, 1);

    // Bad checksum; entry into the load clears the previous done flag.
    state = s_LOAD;
    @(negedge clk);
    checkOutput("entry_clears_done", load_done, 0);
    sendStream(8'h00, 0);
    checkOutput("bad_load_done", load_done, 1);
    checkOutput("bad_chk_err", chk_err, 1);
    checkImage("bad");

    // Gaps in valid, done must stay low until the checksum, extra beat ignored.
    restartLoad();
    for (int n = 0; n < NDATA; n++) applyStimulus(8'(n), $urandom_range(0, 2));
    bus.in_valid = 1'b0;
    checkOutput("gap_done_before_chk", load_done, 0);
    checkImage("gap_pre_chk");
    applyStimulus(8'h6B, 1);
    bus.in_data = 8'hFF;
    #1;
    checkOutput("gap_ready_done", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("gap_load_done", load_done, 1);
    checkOutput("gap_chk_err", chk_err, 0);
    checkImage("gap");

    // Abort after 50 beats, then a complete reload.
    restartLoad();
    for (int n = 0; n < 50; n++) applyStimulus(8'(n), 0);
    state       = s_IDLE;
    bus.in_data = 8'h55;
    #1;
    checkOutput("abort_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("abort_load_done", load_done, 0);
    state = s_LOAD;
    sendStream(8'h6B, 0);
    checkOutput("reload_done", load_done, 1);
    checkOutput("reload_chk_err", chk_err, 0);
    checkImage("reload");

    // Reset in the middle of a load, then a complete load.
    restartLoad();
    for (int n = 0; n < 30; n++) applyStimulus(8'(n), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_pixels", NBITS'(pixels), 0);
    checkOutput("mid_rst_weights", NBITS'(weights), 0);
    checkOutput("mid_rst_load_done", load_done, 0);
    checkOutput("mid_rst_chk_err", chk_err, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    sendStream(8'h6B, 0);
    checkOutput("post_rst_done", load_done, 1);
    checkOutput("post_rst_chk_err", chk_err, 0);
    checkImage("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
